axi_fft_master: RTL and testbench

- AXI initiator that drives the FFT block's AXI slave bridge.
- Per transaction: one INCR write burst of 16-bit samples from an upstream stream, then collect the write response, then wait for calculation end.
- Then issues one INCR read burst and forwards the 32-bit results to a downstream stream.
- Sits between the sample source/sink logic and the FFT AXI slave port.

---
 rtl/axi_fft_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_fft_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fft_master.sv
// AXI initiator for the FFT slave bridge: writes one sample burst, waits for the FFT,
// reads one result burst. Optional response timeout via AXI_FFT_MASTER_TIMEOUT_EN.
module axi_fft_master #(
    parameter int          DATA_WIDTH     = 32,
    parameter int          ID_WIDTH       = 2,
    parameter logic [11:0] BASE_ADDR      = 12'h000,
    parameter int          WR_ID          = 0,
    parameter int          RD_ID          = 1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [7:0]            i_len,
    input  logic [15:0]           i_SAMPLE,
    input  logic                  i_SAMPLE_VALID,
    output logic                  o_SAMPLE_READY,
    output logic [DATA_WIDTH-1:0] o_RESULT,
    output logic                  o_RESULT_VALID,
    input  logic                  i_RESULT_READY,
    output logic [11:0]           o_AWADDR,
    output logic [7:0]            o_AWLEN,
    output logic [2:0]            o_AWSIZE,
    output logic [1:0]            o_AWBURST,
    output logic [ID_WIDTH-1:0]   o_AWID,
    output logic                  o_AWVALID,
    input  logic                  i_AWREADY,
    output logic [15:0]           o_WDATA,
    output logic [1:0]            o_WSTRB,
    output logic                  o_WVALID,
    output logic                  o_WLAST,
    input  logic                  i_WREADY,
    input  logic                  i_BVALID,
    input  logic [ID_WIDTH-1:0]   i_BID,
    output logic                  o_BREADY,
    output logic [11:0]           o_ARADDR,
    output logic [7:0]            o_ARLEN,
    output logic [2:0]            o_ARSIZE,
    output logic [1:0]            o_ARBURST,
    output logic [ID_WIDTH-1:0]   o_ARID,
    output logic                  o_ARVALID,
    input  logic                  i_ARREADY,
    input  logic [DATA_WIDTH-1:0] i_RDATA,
    input  logic [ID_WIDTH-1:0]   i_RID,
    input  logic                  i_RVALID,
    input  logic                  i_RLAST,
    output logic                  o_RREADY,
    input  logic                  i_CALC_END,
    output logic                  o_BUSY,
    output logic                  o_DONE,
    output logic                  o_ERR
);

    localparam logic [2:0]          AR_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ID_WIDTH-1:0] WID     = ID_WIDTH'(WR_ID);
    localparam logic [ID_WIDTH-1:0] RID     = ID_WIDTH'(RD_ID);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_WAIT_CALC, S_AR, S_R, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [8:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       awvalid_q, awvalid_d;
    logic       arvalid_q, arvalid_d;
    logic       bready_q, bready_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    logic in_w, in_r, w_hs, r_hs, last_beat;

    assign in_w      = (state_q == S_W);
    assign in_r      = (state_q == S_R);
    assign w_hs      = in_w && i_SAMPLE_VALID && i_WREADY;
    assign r_hs      = in_r && i_RVALID && i_RESULT_READY;
    // 9-bit counter against zero-extended length so 256-beat bursts never wrap
    assign last_beat = (cnt_q == {1'b0, len_q});

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                len_d   = i_len;
                cnt_d   = '0;
                state_d = S_AW;
            end
            S_AW: if (i_AWREADY) state_d = S_W;
            S_W: if (w_hs) begin
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = S_B;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_B: if (i_BVALID) begin
                state_d = S_WAIT_CALC;
                if (i_BID != WID) err_d = 1'b1;
            end
            S_WAIT_CALC: if (i_CALC_END) state_d = S_AR;
            S_AR: if (i_ARREADY) state_d = S_R;
            S_R: if (r_hs) begin
                if ((i_RLAST != last_beat) || (i_RID != RID)) err_d = 1'b1;
                // the beat count, not RLAST, decides when the burst is over
                if (last_beat) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
        to_cnt_d = '0;
        if ((state_q == S_B || state_q == S_WAIT_CALC || state_q == S_R) &&
            state_d == state_q && !r_hs) begin
            if (to_cnt_q == TO_LAST) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif

        awvalid_d = (state_d == S_AW);
        arvalid_d = (state_d == S_AR);
        bready_d  = (state_d == S_B);
        done_d    = (state_d == S_DONE);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign o_AWADDR  = BASE_ADDR;
    assign o_AWLEN   = len_q;
    assign o_AWSIZE  = 3'b001;
    assign o_AWBURST = 2'b01;
    assign o_AWID    = WID;
    assign o_AWVALID = awvalid_q;

    // W and R channels are zero-latency pass-throughs gated by state
    assign o_WDATA        = in_w ? i_SAMPLE : '0;
    assign o_WSTRB        = 2'b11;
    assign o_WVALID       = in_w && i_SAMPLE_VALID;
    assign o_WLAST        = in_w && last_beat;
    assign o_SAMPLE_READY = in_w && i_WREADY;
    assign o_BREADY       = bready_q;

    assign o_ARADDR  = BASE_ADDR;
    assign o_ARLEN   = len_q;
    assign o_ARSIZE  = AR_SIZE;
    assign o_ARBURST = 2'b01;
    assign o_ARID    = RID;
    assign o_ARVALID = arvalid_q;

    assign o_RESULT       = in_r ? i_RDATA : '0;
    assign o_RESULT_VALID = in_r && i_RVALID;
    assign o_RREADY       = in_r && i_RESULT_READY;

    assign o_BUSY = busy_q;
    assign o_DONE = done_q;
    assign o_ERR  = err_q;

endmodule

// File: tb/tb_axi_fft_master.sv
// Directed bench for axi_fft_master: scoreboarded W/R beats, handshake and error checks.
module tb_axi_fft_master;
`ifdef AXI_FFT_MASTER_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        i_clk = 1'b0, i_rstn = 1'b0, i_start = 1'b0;
    logic [7:0]  i_len = '0;
    logic [15:0] i_SAMPLE = '0;
    logic        i_SAMPLE_VALID = 1'b0, i_RESULT_READY = 1'b0;
    logic        i_AWREADY = 1'b0, i_WREADY = 1'b0, i_BVALID = 1'b0, i_ARREADY = 1'b0;
    logic [1:0]  i_BID = '0, i_RID = '0;
    logic [31:0] i_RDATA = '0;
    logic        i_RVALID = 1'b0, i_RLAST = 1'b0, i_CALC_END = 1'b0;

    logic        o_SAMPLE_READY, o_RESULT_VALID, o_AWVALID, o_WVALID, o_WLAST, o_BREADY;
    logic        o_ARVALID, o_RREADY, o_BUSY, o_DONE, o_ERR;
    logic [31:0] o_RESULT;
    logic [11:0] o_AWADDR, o_ARADDR;
    logic [7:0]  o_AWLEN, o_ARLEN;
    logic [2:0]  o_AWSIZE, o_ARSIZE;
    logic [1:0]  o_AWBURST, o_ARBURST, o_AWID, o_ARID, o_WSTRB;
    logic [15:0] o_WDATA;

    axi_fft_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_len(i_len),
        .i_SAMPLE(i_SAMPLE), .i_SAMPLE_VALID(i_SAMPLE_VALID), .o_SAMPLE_READY(o_SAMPLE_READY),
        .o_RESULT(o_RESULT), .o_RESULT_VALID(o_RESULT_VALID), .i_RESULT_READY(i_RESULT_READY),
        .o_AWADDR(o_AWADDR), .o_AWLEN(o_AWLEN), .o_AWSIZE(o_AWSIZE), .o_AWBURST(o_AWBURST),
        .o_AWID(o_AWID), .o_AWVALID(o_AWVALID), .i_AWREADY(i_AWREADY),
        .o_WDATA(o_WDATA), .o_WSTRB(o_WSTRB), .o_WVALID(o_WVALID), .o_WLAST(o_WLAST),
        .i_WREADY(i_WREADY), .i_BVALID(i_BVALID), .i_BID(i_BID), .o_BREADY(o_BREADY),
        .o_ARADDR(o_ARADDR), .o_ARLEN(o_ARLEN), .o_ARSIZE(o_ARSIZE), .o_ARBURST(o_ARBURST),
        .o_ARID(o_ARID), .o_ARVALID(o_ARVALID), .i_ARREADY(i_ARREADY),
        .i_RDATA(i_RDATA), .i_RID(i_RID), .i_RVALID(i_RVALID), .i_RLAST(i_RLAST),
        .o_RREADY(o_RREADY), .i_CALC_END(i_CALC_END),
        .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_ERR(o_ERR)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] wq[$];
    logic        wlq[$];
    logic [31:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic start_txn(input logic [7:0] len);
        i_start = 1'b1;
        i_len   = len;
        tick();
        i_start = 1'b0;
        #1;
        chk("aw_busy", o_BUSY, 1);
        chk("aw_len", o_AWLEN, len);
        chk("aw_static", {o_AWADDR, o_AWSIZE, o_AWBURST, o_AWID, o_WSTRB},
            {12'h000, 3'b001, 2'b01, 2'd0, 2'b11});
    endtask

    task automatic aw_phase(input int delay);
        int drops = 0;
        for (int k = 0; k < delay; k++) begin
            i_AWREADY = 1'b0;
            #1;
            if (o_AWVALID !== 1'b1) drops++;
            tick();
        end
        chk("awvalid_held", drops, 0);
        i_AWREADY = 1'b1;
        #1;
        chk("awvalid_hs", o_AWVALID, 1);
        tick();
        i_AWREADY = 1'b0;
        #1;
        chk("awvalid_drop", o_AWVALID, 0);
    endtask

    // mode bit0: toggling WREADY, bit1: random SAMPLE_VALID gaps
    task automatic w_phase(input int n, input int len, input logic [15:0] base, input int mode);
        int acc = 0, pushed = 0, cyc = 0;
        while (acc < n && cyc < 4 * n + 20) begin
            i_SAMPLE       = base + 16'(acc);
            i_SAMPLE_VALID = mode[1] ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_WREADY       = mode[0] ? (cyc % 2 == 0) : 1'b1;
            if (i_SAMPLE_VALID && pushed == acc) begin
                wq.push_back(base + 16'(acc));
                wlq.push_back(acc == len);
                pushed++;
            end
            #1;
            if (o_WVALID && i_WREADY) begin
                chk("w_expected_beat", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    chk("wdata", o_WDATA, wq.pop_front());
                    chk("wlast", o_WLAST, wlq.pop_front());
                end
                acc++;
            end
            tick();
            cyc++;
        end
        i_SAMPLE_VALID = 1'b0;
        i_WREADY       = 1'b0;
        chk("w_beats", acc, n);
    endtask

    task automatic b_phase(input logic [1:0] bid);
        i_BVALID = 1'b1;
        i_BID    = bid;
        #1;
        chk("bready_hi", o_BREADY, 1);
        tick();
        i_BVALID = 1'b0;
        i_BID    = '0;
        #1;
        chk("bready_lo", o_BREADY, 0);
        chk("wait_busy", o_BUSY, 1);
        chk("wait_arvalid", o_ARVALID, 0);
    endtask

    task automatic calc_ar(input logic [7:0] len);
        i_start = 1'b1;
        i_len   = 8'h55;
        tick();
        tick();
        i_start    = 1'b0;
        chk("calc_wait_arvalid", o_ARVALID, 0);
        i_CALC_END = 1'b1;
        tick();
        i_CALC_END = 1'b0;
        #1;
        chk("arvalid", o_ARVALID, 1);
        chk("ar_len", o_ARLEN, len);
        chk("ar_static", {o_ARADDR, o_ARSIZE, o_ARBURST, o_ARID},
            {12'h000, 3'd2, 2'b01, 2'd1});
        i_ARREADY = 1'b1;
        tick();
        i_ARREADY = 1'b0;
    endtask

    // mode bit0: toggling RESULT_READY, bit1: random RVALID gaps
    task automatic r_phase(input int n, input int rlast_at, input logic [1:0] rid, input int mode);
        int acc = 0, pushed = 0, cyc = 0;
        while (acc < n && cyc < 4 * n + 20) begin
            i_RVALID       = mode[1] ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_RDATA        = 32'hA0 + 32'(acc);
            i_RLAST        = (acc == rlast_at);
            i_RID          = rid;
            i_RESULT_READY = mode[0] ? (cyc % 2 == 0) : 1'b1;
            if (i_RVALID && pushed == acc) begin
                rq.push_back(32'hA0 + 32'(acc));
                pushed++;
            end
            #1;
            if (o_RESULT_VALID && i_RESULT_READY) begin
                chk("r_expected_beat", 32'(rq.size() != 0), 1);
                if (rq.size() != 0) chk("result", o_RESULT, rq.pop_front());
                acc++;
            end
            tick();
            cyc++;
        end
        i_RVALID       = 1'b0;
        i_RLAST        = 1'b0;
        i_RESULT_READY = 1'b0;
        chk("r_beats", acc, n);
        #1;
        chk("done_pulse", o_DONE, 1);
        tick();
        chk("done_clear", o_DONE, 0);
        chk("idle_busy", o_BUSY, 0);
    endtask

    task automatic full_txn(input int n, input int mode, input int rlast_at, input logic [1:0] bid);
        start_txn(8'(n - 1));
        aw_phase(mode != 0 ? 5 : 0);
        w_phase(n, n - 1, 16'h0001, mode);
        b_phase(bid);
        calc_ar(8'(n - 1));
        r_phase(n, rlast_at, 2'd1, mode);
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        #1;
        chk("rst_busy", o_BUSY, 0);
        chk("rst_err", o_ERR, 0);
        chk("rst_valids", {o_AWVALID, o_WVALID, o_ARVALID, o_RESULT_VALID, o_DONE}, 0);
        chk("rst_readies", {o_BREADY, o_RREADY, o_SAMPLE_READY, o_WLAST}, 0);
        chk("rst_len", o_AWLEN, 0);
        tick();
        i_rstn = 1'b1;
        wq.delete();
        wlq.delete();
        rq.delete();
        tick();
    endtask

    initial begin
        @(negedge i_clk);
        do_reset();

        // basic 4-beat transaction, samples 0x0001..0x0004, results A0..A3
        full_txn(4, 0, 3, 2'd0);
        chk("t2_err", o_ERR, 0);

        // backpressure on every channel
        full_txn(4, 3, 3, 2'd0);
        chk("t3_err", o_ERR, 0);

        // maximum length burst
        full_txn(256, 0, 255, 2'd0);
        chk("t4_err", o_ERR, 0);

        // early RLAST flags an error, burst still runs 4 beats, flag is sticky
        full_txn(4, 0, 1, 2'd0);
        chk("rlast_err", o_ERR, 1);
        full_txn(4, 0, 3, 2'd0);
        chk("err_sticky", o_ERR, 1);
        do_reset();

        // bad BID
        start_txn(8'd3);
        aw_phase(0);
        w_phase(4, 3, 16'h0001, 0);
        b_phase(2'd3);
        chk("bid_err", o_ERR, 1);
        calc_ar(8'd3);
        r_phase(4, 3, 2'd1, 0);
        chk("bid_err_sticky", o_ERR, 1);
        do_reset();

        // reset in the middle of the write burst
        start_txn(8'd3);
        aw_phase(0);
        w_phase(2, 3, 16'h0001, 0);
        i_SAMPLE_VALID = 1'b1;
        i_WREADY       = 1'b1;
        #1;
        chk("midw_wvalid", o_WVALID, 1);
        do_reset();
        i_SAMPLE_VALID = 1'b0;
        i_WREADY       = 1'b0;

        // single-beat burst
        start_txn(8'd0);
        aw_phase(0);
        w_phase(1, 0, 16'hBEEF, 0);
        b_phase(2'd0);
        calc_ar(8'd0);
        r_phase(1, 0, 2'd1, 0);
        chk("single_err", o_ERR, 0);

`ifdef AXI_FFT_MASTER_TIMEOUT_EN
        start_txn(8'd3);
        aw_phase(0);
        w_phase(4, 3, 16'h0001, 0);
        repeat (15) tick();
        chk("to_not_yet_busy", o_BUSY, 1);
        chk("to_not_yet_err", o_ERR, 0);
        tick();
        chk("to_idle", o_BUSY, 0);
        chk("to_err", o_ERR, 1);
        chk("to_no_done", o_DONE, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
